// File: rtl/z80_mmio_ctrl.sv
// z80_mmio_ctrl -- memory-mapped I/O slave for the Z80 system bus.
//
// Combines input-port reads, a bank of single-bit write latches and a
// vblank-driven NMI generator behind one decoder select.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   ena        slave select from the address decoder
//   ibus       master bus: addr, dmaster, rdn, wrn (strobes active low)
//   obus       slave bus: dslave (registered read data), mwait (active low)
//   in_ports   N_IN 8-bit input ports, port k at bits [8k+7:8k]
//   vblk       vertical blank level
//   latches    N_LATCH latch outputs
//   nmi_n      active-low NMI to the CPU

package z80_bus_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dmaster;
    logic        rdn;
    logic        wrn;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

// One write latch. The polarity flip is applied on the way in, so q is the
// value presented on the latches output.
module z80_mmio_latch_bit #(
  parameter bit INV = 1'b0,
  parameter bit RST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RST;
    else if (we) q <= d ^ INV;
  end
endmodule

module z80_mmio_ctrl
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] IN_BASE        = 16'h7C00,
  parameter int          IN_STRIDE_LOG2 = 7,
  parameter int          N_IN           = 4,
  parameter logic [15:0] LATCH_BASE     = 16'h7D80,
  parameter int          N_LATCH        = 8,
  parameter logic [15:0] LATCH_INV      = 16'h0007,
  parameter logic [15:0] LATCH_RST      = 16'h0007,
  parameter int          NMI_BIT        = 4,
  parameter int          NMI_PULSE      = 0,
  parameter int          WAIT_STATES    = 0,
  parameter logic [7:0]  RD_DEFAULT     = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  Z80MasterBus             ibus,
  output Z80SlaveBus              obus,
  input  logic [N_IN-1:0][7:0]    in_ports,
  input  logic                    vblk,
  output logic [N_LATCH-1:0]      latches,
  output logic                    nmi_n
);

  // Elaboration-time range checks
  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("z80_mmio_ctrl: N_IN must be 1..8");
  end
  if (N_LATCH < 1 || N_LATCH > 16) begin : g_bad_n_latch
    $error("z80_mmio_ctrl: N_LATCH must be 1..16");
  end
  if (NMI_BIT < 0 || NMI_BIT >= N_LATCH) begin : g_bad_nmi_bit
    $error("z80_mmio_ctrl: NMI_BIT must index an existing latch");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
    $error("z80_mmio_ctrl: WAIT_STATES must be 0..7");
  end

  localparam logic [2:0]  WS_LOAD    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [15:0] PULSE_LOAD = (NMI_PULSE > 0) ? 16'(NMI_PULSE - 1) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t     state, state_nxt;
  logic [2:0] wcnt, wcnt_nxt;
  logic       mwait_q, mwait_nxt;
  logic [7:0] dslave_q, rd_data;

  logic strobe, start, rd_start, wr_start;

  assign strobe   = !ibus.rdn || !ibus.wrn;
  // One action per access: only the IDLE->busy transition acts, so a strobe
  // held across many cycles cannot re-trigger a read or latch write.
  assign start    = (state == S_IDLE) && ena && strobe;
  assign wr_start = start && !ibus.wrn;
  assign rd_start = start && !ibus.rdn && ibus.wrn;

  // ---------------- access FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= 3'd0;
      mwait_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      mwait_q <= mwait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    mwait_nxt = mwait_q;
    if (!ena) begin
      // losing the select aborts whatever is in flight
      state_nxt = S_IDLE;
      mwait_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (strobe) begin
            if (WAIT_STATES > 0) begin
              state_nxt = S_WAIT;
              mwait_nxt = 1'b0;
              wcnt_nxt  = WS_LOAD;
            end else begin
              state_nxt = S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 3'd0) begin
            state_nxt = S_HOLD;
            mwait_nxt = 1'b1;
          end else begin
            wcnt_nxt = wcnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (!strobe) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_data = RD_DEFAULT;
    for (int k = 0; k < N_IN; k++) begin
      if (ibus.addr == 16'(IN_BASE + (k << IN_STRIDE_LOG2))) rd_data = in_ports[k];
    end
  end

  // Captured at the access-start edge, so data is stable before mwait releases.
  always_ff @(posedge clk) begin
    if (rst)           dslave_q <= RD_DEFAULT;
    else if (rd_start) dslave_q <= rd_data;
  end

  assign obus = {dslave_q, mwait_q};

  // ---------------- write latches ----------------
  logic [N_LATCH-1:0] latch_we;

  for (genvar n = 0; n < N_LATCH; n++) begin : g_latch
    assign latch_we[n] = wr_start && (ibus.addr == 16'(LATCH_BASE + n));
    z80_mmio_latch_bit #(
      .INV (LATCH_INV[n]),
      .RST (LATCH_RST[n])
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .we  (latch_we[n]),
      .d   (ibus.dmaster[0]),
      .q   (latches[n])
    );
  end

  logic unused_dmaster;
  assign unused_dmaster = ^ibus.dmaster[7:1];

  // ---------------- NMI ----------------
  logic        vblk_q, nmi_q, rise, mask, mask_clr;
  logic [15:0] pcnt;

  assign rise = vblk && !vblk_q;
  assign mask = latches[NMI_BIT];
  // A mask-clearing write landing on the same edge as a vblank rise must
  // suppress the NMI, so look at the latch's incoming value, not just q.
  assign mask_clr = latch_we[NMI_BIT] && !(ibus.dmaster[0] ^ LATCH_INV[NMI_BIT]);

  always_ff @(posedge clk) begin
    if (rst) begin
      vblk_q <= 1'b0;
      nmi_q  <= 1'b1;
      pcnt   <= 16'd0;
    end else begin
      vblk_q <= vblk;
      if (!nmi_q) begin
        // active: further edges are ignored, counter is never reloaded here
        if (!mask) begin
          nmi_q <= 1'b1;
        end else if (NMI_PULSE > 0) begin
          if (pcnt == 16'd0) nmi_q <= 1'b1;
          else               pcnt  <= pcnt - 16'd1;
        end
      end else if (rise && mask && !mask_clr) begin
        nmi_q <= 1'b0;
        pcnt  <= PULSE_LOAD;
      end
    end
  end

  assign nmi_n = nmi_q;

endmodule
